// File: rtl/sd_mon_pkg.sv
// Shared types for the srdy/drdy protocol monitor: error codes and capture FSM states.
package sd_mon_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_DROP = 2'b01,
        ERR_HOLD = 2'b10,
        ERR_TMO  = 2'b11
    } err_code_e;

    typedef enum logic {
        ARMED   = 1'b0,
        LATCHED = 1'b1
    } cap_state_e;

endpackage

// File: rtl/sd_mon_chan.sv
// Per-channel checker: stall tracking, sticky drop/hold/timeout flags, saturating transfer count.
module sd_mon_chan
    import sd_mon_pkg::*;
#(
    parameter int width   = 8,
    parameter int timeout = 16,
    parameter int tmo_w   = 8,
    parameter int cnt_w   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             srdy_i,
    input  logic             drdy_i,
    input  logic [width-1:0] data_i,
    output logic             err_drop_o,
    output logic             err_hold_o,
    output logic             err_tmo_o,
    output logic [cnt_w-1:0] xfer_cnt_o,
    output err_code_e        evt_code_o
);

    localparam logic [tmo_w-1:0] TMO_MAX  = tmo_w'(timeout);
    localparam logic [tmo_w-1:0] TMO_LAST = tmo_w'(timeout - 1);

    logic             pend_q, pend_d;
    logic [width-1:0] data_q;
    logic [tmo_w-1:0] stall_q, stall_d;
    logic [cnt_w-1:0] xfer_q, xfer_d;
    logic             drop_q, drop_d;
    logic             hold_q, hold_d;
    logic             tmo_q, tmo_d;
    logic             evt_drop, evt_hold, evt_tmo;

    always_comb begin
        pend_d   = srdy_i && !drdy_i && enable_i;
        evt_drop = enable_i && pend_q && !srdy_i;
        evt_hold = enable_i && pend_q && srdy_i && (data_i != data_q);
        evt_tmo  = pend_d && (stall_q == TMO_LAST);

        // The stall counter parks at timeout so one long stall flags only once.
        stall_d = '0;
        if (pend_d && !clear_i) begin
            stall_d = (stall_q == TMO_MAX) ? stall_q : stall_q + 1'b1;
        end

        xfer_d = xfer_q;
        if (clear_i) begin
            xfer_d = '0;
        end else if (srdy_i && drdy_i && enable_i && (xfer_q != '1)) begin
            xfer_d = xfer_q + 1'b1;
        end

        drop_d = clear_i ? 1'b0 : (drop_q || evt_drop);
        hold_d = clear_i ? 1'b0 : (hold_q || evt_hold);
        tmo_d  = clear_i ? 1'b0 : (tmo_q || evt_tmo);

        evt_code_o = ERR_NONE;
        if (evt_drop) begin
            evt_code_o = ERR_DROP;
        end else if (evt_hold) begin
            evt_code_o = ERR_HOLD;
        end else if (evt_tmo) begin
            evt_code_o = ERR_TMO;
        end
    end

    // pend_q/data_q load even during clear so a stall spanning clear stays checked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            data_q  <= '0;
            stall_q <= '0;
            xfer_q  <= '0;
            drop_q  <= 1'b0;
            hold_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            data_q  <= data_i;
            stall_q <= stall_d;
            xfer_q  <= xfer_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign err_drop_o = drop_q;
    assign err_hold_o = hold_q;
    assign err_tmo_o  = tmo_q;
    assign xfer_cnt_o = xfer_q;

endmodule

// File: rtl/sd_proto_monitor.sv
// Multi-channel srdy/drdy protocol monitor: per-channel checkers plus a first-error capture record.
module sd_proto_monitor
    import sd_mon_pkg::*;
#(
    parameter int width    = 8,
    parameter int channels = 4,
    parameter int timeout  = 16,
    parameter int tmo_w    = 8,
    parameter int cnt_w    = 16
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              enable,
    input  logic                                              clear,
    input  logic [channels-1:0]                               ch_srdy,
    input  logic [channels-1:0]                               ch_drdy,
    input  logic [channels*width-1:0]                         ch_data,
    output logic [channels-1:0]                               err_drop,
    output logic [channels-1:0]                               err_hold,
    output logic [channels-1:0]                               err_tmo,
    output logic [channels*cnt_w-1:0]                         xfer_cnt,
    output logic                                              first_valid,
    output logic [((channels > 1) ? $clog2(channels) : 1)-1:0] first_chan,
    output logic [1:0]                                        first_code,
    output logic                                              irq
);

    localparam int CHW = (channels > 1) ? $clog2(channels) : 1;

    err_code_e      evt_code [channels];
    logic           hit;
    logic [CHW-1:0] hit_chan;
    err_code_e      hit_code;

    cap_state_e     state_q, state_d;
    logic [CHW-1:0] chan_q, chan_d;
    err_code_e      code_q, code_d;

    for (genvar gi = 0; gi < channels; gi++) begin : g_chan
        sd_mon_chan #(
            .width   (width),
            .timeout (timeout),
            .tmo_w   (tmo_w),
            .cnt_w   (cnt_w)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable_i   (enable),
            .clear_i    (clear),
            .srdy_i     (ch_srdy[gi]),
            .drdy_i     (ch_drdy[gi]),
            .data_i     (ch_data[gi*width +: width]),
            .err_drop_o (err_drop[gi]),
            .err_hold_o (err_hold[gi]),
            .err_tmo_o  (err_tmo[gi]),
            .xfer_cnt_o (xfer_cnt[gi*cnt_w +: cnt_w]),
            .evt_code_o (evt_code[gi])
        );
    end

    // Scan downwards so the lowest-numbered channel with an event wins.
    always_comb begin
        hit      = 1'b0;
        hit_chan = '0;
        hit_code = ERR_NONE;
        for (int i = channels - 1; i >= 0; i--) begin
            if (evt_code[i] != ERR_NONE) begin
                hit      = 1'b1;
                hit_chan = CHW'(i);
                hit_code = evt_code[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        code_d  = code_q;
        case (state_q)
            ARMED: begin
                if (hit) begin
                    state_d = LATCHED;
                    chan_d  = hit_chan;
                    code_d  = hit_code;
                end
            end
            LATCHED: begin
                state_d = LATCHED;
            end
            default: begin
                state_d = ARMED;
            end
        endcase
        if (clear) begin
            state_d = ARMED;
            chan_d  = '0;
            code_d  = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARMED;
            chan_q  <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            code_q  <= code_d;
        end
    end

    assign first_valid = (state_q == LATCHED);
    assign first_chan  = chan_q;
    assign first_code  = code_q;
    assign irq         = (state_q == LATCHED);

endmodule

// File: tb/tb_sd_proto_monitor.sv
// Randomized and directed bench for sd_proto_monitor, checked against a cycle-level behavioural model.
module tb_sd_proto_monitor;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int TMO  = 16;
    localparam int TW   = 8;
    localparam int CW   = 5;
    localparam int CHW  = 2;
    localparam int XMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              clear;
    logic [CH-1:0]     ch_srdy;
    logic [CH-1:0]     ch_drdy;
    logic [CH*W-1:0]   ch_data;
    logic [CH-1:0]     err_drop;
    logic [CH-1:0]     err_hold;
    logic [CH-1:0]     err_tmo;
    logic [CH*CW-1:0]  xfer_cnt;
    logic              first_valid;
    logic [CHW-1:0]    first_chan;
    logic [1:0]        first_code;
    logic              irq;

    int assertCount = 0;
    int failCount   = 0;

    bit           prevStall [CH];
    logic [W-1:0] prevData  [CH];
    int           stallLen  [CH];
    int           xferTotal [CH];
    bit           mDrop     [CH];
    bit           mHold     [CH];
    bit           mTmo      [CH];
    bit           mValid;
    int           mChan;
    int           mCode;
    int           drdyPct   [CH];

    sd_proto_monitor #(
        .width    (W),
        .channels (CH),
        .timeout  (TMO),
        .tmo_w    (TW),
        .cnt_w    (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (clear),
        .ch_srdy     (ch_srdy),
        .ch_drdy     (ch_drdy),
        .ch_data     (ch_data),
        .err_drop    (err_drop),
        .err_hold    (err_hold),
        .err_tmo     (err_tmo),
        .xfer_cnt    (xfer_cnt),
        .first_valid (first_valid),
        .first_chan  (first_chan),
        .first_code  (first_code),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            prevStall[i] = 1'b0;
            prevData[i]  = '0;
            stallLen[i]  = 0;
            xferTotal[i] = 0;
            mDrop[i]     = 1'b0;
            mHold[i]     = 1'b0;
            mTmo[i]      = 1'b0;
        end
        mValid = 1'b0;
        mChan  = 0;
        mCode  = 0;
    endtask

    // One clock of protocol rules applied to the inputs currently on the bus.
    task automatic modelStep();
        bit found = 1'b0;
        int eChan = 0;
        int eCode = 0;
        for (int i = 0; i < CH; i++) begin
            bit s, d, pendNow, isDrop, isHold, isTmo;
            logic [W-1:0] dat;
            s       = ch_srdy[i];
            d       = ch_drdy[i];
            dat     = ch_data[i*W +: W];
            pendNow = s && !d && enable;
            isDrop  = enable && prevStall[i] && !s;
            isHold  = enable && prevStall[i] && s && (dat != prevData[i]);
            isTmo   = pendNow && (stallLen[i] + 1 == TMO);
            if (!found && (isDrop || isHold || isTmo)) begin
                found = 1'b1;
                eChan = i;
                eCode = isDrop ? 1 : (isHold ? 2 : 3);
            end
            stallLen[i] = (pendNow && !clear) ? stallLen[i] + 1 : 0;
            if (clear) begin
                xferTotal[i] = 0;
                mDrop[i] = 1'b0;
                mHold[i] = 1'b0;
                mTmo[i]  = 1'b0;
            end else begin
                if (s && d && enable) xferTotal[i]++;
                mDrop[i] = mDrop[i] | isDrop;
                mHold[i] = mHold[i] | isHold;
                mTmo[i]  = mTmo[i] | isTmo;
            end
            prevStall[i] = pendNow;
            prevData[i]  = dat;
        end
        if (clear) begin
            mValid = 1'b0;
            mChan  = 0;
            mCode  = 0;
        end else if (!mValid && found) begin
            mValid = 1'b1;
            mChan  = eChan;
            mCode  = eCode;
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < CH; i++) begin
            int expCnt;
            expCnt = (xferTotal[i] > XMAX) ? XMAX : xferTotal[i];
            checkOutput($sformatf("err_drop[%0d]", i), err_drop[i], mDrop[i]);
            checkOutput($sformatf("err_hold[%0d]", i), err_hold[i], mHold[i]);
            checkOutput($sformatf("err_tmo[%0d]", i), err_tmo[i], mTmo[i]);
            checkOutput($sformatf("xfer_cnt[%0d]", i), xfer_cnt[i*CW +: CW], expCnt);
        end
        checkOutput("first_valid", first_valid, mValid);
        checkOutput("irq", irq, mValid);
        checkOutput("first_chan", first_chan, mChan);
        checkOutput("first_code", first_code, mCode);
    endtask

    task automatic applyStimulus(input logic [CH-1:0] s, input logic [CH-1:0] d,
                                 input logic [CH*W-1:0] dat, input logic e, input logic c);
        ch_srdy = s;
        ch_drdy = d;
        ch_data = dat;
        enable  = e;
        clear   = c;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    // Reset lands between edges; outputs must collapse without waiting for a clock.
    task automatic midReset();
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        ch_srdy = '0;
        ch_drdy = '0;
        ch_data = '0;
        enable  = 1'b0;
        clear   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus('0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [CH*W-1:0] dat;
        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        ch_srdy = '0;
        ch_drdy = '0;
        ch_data = '0;
        #12;
        modelReset();
        checkAll();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus('0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < CH; i++) dat[i*W +: W] = W'($urandom);
        for (int k = 0; k < 28; k++) begin
            applyStimulus('1, (k % 4 == 3) ? '1 : '0, dat, 1'b1, 1'b0);
            if (k % 4 == 3) begin
                for (int i = 0; i < CH; i++) dat[i*W +: W] = W'($urandom);
            end
        end
        checkOutput("legalNoErr", {err_drop, err_hold, err_tmo}, 0);
        checkOutput("legalXfer0", xfer_cnt[0 +: CW], 7);
        checkOutput("legalNoCapture", first_valid, 0);

        applyStimulus(4'b0010, 4'b0000, dat, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, dat, 1'b1, 1'b0);
        checkOutput("dropFlags", err_drop, 4'b0010);
        checkOutput("dropChan", first_chan, 1);
        checkOutput("dropCode", first_code, 2'b01);
        checkOutput("dropIrq", irq, 1);
        applyStimulus('0, '0, dat, 1'b1, 1'b1);
        checkOutput("clearValid", first_valid, 0);
        checkOutput("clearXfer", xfer_cnt, 0);

        dat = '0;
        dat[0*W +: W] = 8'h11;
        dat[3*W +: W] = 8'h44;
        applyStimulus(4'b1001, 4'b0000, dat, 1'b1, 1'b0);
        dat[0*W +: W] = 8'h22;
        applyStimulus(4'b0001, 4'b0000, dat, 1'b1, 1'b0);
        checkOutput("simulChan", first_chan, 0);
        checkOutput("simulCode", first_code, 2'b10);
        checkOutput("simulDrop", err_drop, 4'b1000);
        checkOutput("simulHold", err_hold, 4'b0001);
        dat[0*W +: W] = 8'h33;
        applyStimulus(4'b0001, 4'b0000, dat, 1'b1, 1'b1);
        checkOutput("clrCycleHold", err_hold, 0);
        checkOutput("clrCycleValid", first_valid, 0);
        applyStimulus(4'b0001, 4'b0001, dat, 1'b1, 1'b0);
        checkOutput("afterClrHold", err_hold, 0);
        checkOutput("afterClrXfer", xfer_cnt[0 +: CW], 1);

        applyStimulus(4'b0100, 4'b0000, dat, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, dat, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, dat, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, dat, 1'b1, 1'b0);
        dat[2*W +: W] = 8'h5A;
        applyStimulus(4'b0100, 4'b0000, dat, 1'b0, 1'b0);
        dat[2*W +: W] = 8'hA5;
        applyStimulus(4'b0100, 4'b0000, dat, 1'b1, 1'b0);
        checkOutput("enableFlushDrop", err_drop, 0);
        checkOutput("enableFlushHold", err_hold, 0);
        applyStimulus(4'b0000, 4'b0100, dat, 1'b1, 1'b1);

        for (int k = 1; k <= 20; k++) begin
            applyStimulus(4'b1000, 4'b0000, dat, 1'b1, 1'b0);
            checkOutput($sformatf("tmoEdge%0d", k), err_tmo[3], (k >= TMO) ? 1 : 0);
        end
        checkOutput("tmoCode", first_code, 2'b11);
        checkOutput("tmoChan", first_chan, 3);
        applyStimulus(4'b1000, 4'b0000, dat, 1'b1, 1'b0);
        midReset();

        for (int i = 0; i < CH; i++) drdyPct[i] = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [CH-1:0]   s;
            logic [CH-1:0]   d;
            logic [CH*W-1:0] rdat;
            logic            e;
            logic            c;
            if (cyc % 64 == 0) begin
                for (int i = 0; i < CH; i++) begin
                    case ($urandom_range(0, 2))
                        0:       drdyPct[i] = 3;
                        1:       drdyPct[i] = 40;
                        default: drdyPct[i] = 85;
                    endcase
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (prevStall[i]) begin
                    s[i] = ($urandom_range(0, 49) != 0);
                    rdat[i*W +: W] = ($urandom_range(0, 49) == 0) ? W'($urandom) : prevData[i];
                end else begin
                    s[i] = ($urandom_range(0, 99) < 60);
                    rdat[i*W +: W] = W'($urandom);
                end
                d[i] = ($urandom_range(0, 99) < drdyPct[i]);
            end
            e = ($urandom_range(0, 39) != 0);
            c = ($urandom_range(0, 149) == 0);
            applyStimulus(s, d, rdat, e, c);
            if (cyc == 1000 || cyc == 2000) midReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sd_proto_monitor.md
Name: sd_proto_monitor

Overview:
- Synthesizable, multi-channel srdy/drdy protocol monitor. It is the runtime successor to the formal two-port handshake checker.
- Watches CHANNELS independent srdy/drdy/data interfaces and detects three violations: srdy dropped before drdy, data changed while stalled, and stall exceeding a timeout.
- Keeps sticky per-channel error flags, saturating transfer counters, and a first-error capture record with an interrupt.
- Sits beside any sd_* pipeline stage in simulation, emulation or silicon debug builds.

Parameters:
- width, 8, data bits per channel
- channels, 4, number of monitored interfaces (1..32)
- timeout, 16, stall cycles tolerated before a timeout error (2..2^tmo_w-1)
- tmo_w, 8, stall counter width
- cnt_w, 16, transfer counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  monitoring enable; when low, no detection and pending state is flushed
- clear  in  1  synchronous clear of flags, counters and capture record
- ch_srdy  in  channels  per-channel srdy
- ch_drdy  in  channels  per-channel drdy
- ch_data  in  channels*width  per-channel data; channel i occupies bits [i*width +: width]
- err_drop  out  channels  sticky: srdy fell without drdy
- err_hold  out  channels  sticky: data changed while stalled
- err_tmo  out  channels  sticky: stall reached timeout
- xfer_cnt  out  channels*cnt_w  saturating transfer count per channel
- first_valid  out  1  capture record valid
- first_chan  out  $clog2(channels) (min 1)  channel of first error
- first_code  out  2  code of first error: 01 drop, 10 hold, 11 timeout
- irq  out  1  high while first_valid

Behaviour:
- Reset (reset_n low, async): all outputs 0, all internal registers 0, FSM in ARMED.
- Per channel, register pend = srdy && !drdy && enable, and register data_q = data.
- Drop error: pend_q && !srdy. Flag is set at the clock edge after the offending cycle (1-cycle latency).
- Hold error: pend_q && srdy && data != data_q. Flag latency is 1 cycle.
- Drop and hold are mutually exclusive per cycle. A transfer (srdy && drdy) on a stalled channel with changed data is still a hold error.
- Stall counter: increments each cycle pend is true; resets to 0 on transfer, on srdy low, or when enable is low.
  - When the counter reaches timeout, err_tmo is set once.
  - The counter then saturates at timeout, so the error is not re-flagged during the same stall.
- Transfer counter: increments on srdy && drdy && enable and saturates at 2^cnt_w-1.
- All error flags are sticky until clear or reset.
- enable low: no flags or counters update and pend_q is forced to 0. The first cycle after enable rises can never report drop or hold.
- Capture FSM, states ARMED and LATCHED:
  - ARMED -> LATCHED on any new error event in a cycle. It records first_chan/first_code and sets first_valid.
  - Simultaneous events are resolved by the lowest channel index first, then code priority drop > hold > timeout.
  - LATCHED ignores further events, but sticky flags still accumulate.
  - LATCHED -> ARMED only on clear.
- clear (synchronous, 1 cycle):
  - Zeroes all flags, transfer counters, stall counters and the capture record, and sets FSM = ARMED.
  - clear has priority: events detected in the clear cycle are discarded.
  - pend_q/data_q still load normally, so a stall that spans clear keeps being checked.
- Reset mid-stall: all state is lost and no error is reported for the interrupted stall.

Decomposition:
- Package sd_mon_pkg holds:
  - the error code enum (ERR_NONE=2'b00, ERR_DROP=2'b01, ERR_HOLD=2'b10, ERR_TMO=2'b11)
  - the FSM state enum (ARMED, LATCHED)
- One sub-module, sd_mon_chan, is instantiated per channel with a generate loop. It holds pend_q/data_q, the stall counter, the transfer counter, the three sticky flags and per-cycle event strobes.
- The top level holds the priority encoder and the capture FSM.

Test Plan:
- Legal traffic on all 4 channels: srdy held through 3-cycle stalls with stable data, then 100 transfers each -> no flags, first_valid=0, xfer_cnt=100 per channel.
- ch1 srdy high and drdy low at cycle 10, srdy low at cycle 11 -> err_drop[1]=1 at the edge ending cycle 11, first_chan=1, first_code=01, irq=1.
- ch2 stalled, data changes 0x5A->0xA5 mid-stall -> err_hold[2]=1 one cycle later. A later drop on ch0 leaves first_chan=2, first_code=10 unchanged, while err_drop[0] still sets.
- ch3 stalled 20 cycles with timeout=16 -> err_tmo[3] sets exactly when the stall counter reaches 16, once only. first_code=11.
- Same cycle drop on ch3 and hold on ch0 -> first_chan=0, first_code=10. Then pulse clear -> all flags 0, first_valid=0, xfer_cnt=0. An error in the clear cycle is not recorded.
- With cnt_w=4, drive 20 transfers on ch0 -> xfer_cnt[0] saturates at 15. Toggle enable low during a stall, then release -> no drop or hold reported. Assert reset_n low mid-stall -> all outputs 0 immediately.
